// File: rtl/connect4_pkg.sv
// Shared types and board-size defaults for the drop-slot allocator.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package connect4_pkg;

   // Response code returned with every accepted drop request
   typedef enum logic [1:0] {
      ERR_NONE   = 2'd0,
      ERR_FULL   = 2'd1,
      ERR_BADSEL = 2'd2
   } resp_err_t;

   localparam int DEF_NUM_COLS = 4;
   localparam int DEF_NUM_ROWS = 4;

   // Linear slot index, row-major with row 0 at the bottom
   function automatic int slot_index(input int row, input int col, input int num_cols);
      return row * num_cols + col;
   endfunction

endpackage

// File: rtl/move_history_lifo.sv
// Move-history stack: remembers the column of each successful drop so it can be undone.
// Latency: push/pop take effect at the clock edge; data shows the current top combinationally.
// Backpressure: push is ignored when full, pop is ignored when empty; clear empties the stack.
module move_history_lifo #(
   parameter  int DEPTH  = 16,
   parameter  int DATA_W = 2,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic              empty,
   output logic              full,
   output logic [DATA_W-1:0] data
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [CNT_W-1:0]  cnt;

   assign empty = (cnt == '0);
   assign full  = (cnt == CNT_W'(DEPTH));
   assign data  = mem[ADDR_W'(cnt - 1'b1)];

   // Occupancy: clear wins, then push, then pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (push && !full) begin
         cnt <= cnt + 1'b1;
      end else if (pop && !empty) begin
         cnt <= cnt - 1'b1;
      end
   end

   // Storage needs no reset: entries above the count are never read
   always_ff @(posedge clk) begin
      if (push && !full && !clear) begin
         mem[ADDR_W'(cnt)] <= push_data;
      end
   end

endmodule

// File: rtl/drop_slot_allocator.sv
// Column-drop slot allocator; optional undo history under macro DROP_UNDO_EN.
// Latency: one cycle from accepted request (or undo) to resp_valid (or undo_ack).
// Backpressure: req_ready is low only while clear is high; requests then are dropped.
module drop_slot_allocator
   import connect4_pkg::*;
#(
   parameter  int NUM_COLS = DEF_NUM_COLS,
   parameter  int NUM_ROWS = DEF_NUM_ROWS,
   localparam int POS_W    = $clog2(NUM_COLS * NUM_ROWS),
   localparam int ROW_W    = $clog2(NUM_ROWS),
   localparam int HGT_W    = $clog2(NUM_ROWS + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [NUM_COLS-1:0] req_column,
   output logic                resp_valid,
   output logic [POS_W-1:0]    resp_position,
   output logic [ROW_W-1:0]    resp_row,
   output logic [1:0]          resp_err,
   output logic [NUM_COLS-1:0] col_full,
`ifdef DROP_UNDO_EN
   input  logic                undo_req,
   output logic                undo_ack,
`endif
   output logic                board_full
);

   localparam int COL_W = $clog2(NUM_COLS);

   logic [HGT_W-1:0] height [NUM_COLS];
   logic             accept;
   logic             any_zero;
   logic             multi_zero;
   logic             sel_ok;
   logic [COL_W-1:0] sel_col;
   logic [HGT_W-1:0] sel_h;
   logic [POS_W-1:0] drop_pos;

   assign req_ready = ~clear;
   assign accept    = req_valid & req_ready;

   // Active-low one-hot decode: remember the zero bit and whether there was more than one
   always_comb begin
      any_zero   = 1'b0;
      multi_zero = 1'b0;
      sel_col    = '0;
      for (int c = 0; c < NUM_COLS; c++) begin
         if (!req_column[c]) begin
            if (any_zero) multi_zero = 1'b1;
            any_zero = 1'b1;
            sel_col  = COL_W'(c);
         end
      end
   end

   assign sel_ok   = any_zero & ~multi_zero;
   assign sel_h    = height[sel_col];
   assign drop_pos = POS_W'(slot_index(int'(sel_h), int'(sel_col), NUM_COLS));

   // Full flags decoded straight from the height registers
   always_comb begin
      col_full = '0;
      for (int c = 0; c < NUM_COLS; c++) begin
         col_full[c] = (height[c] == HGT_W'(NUM_ROWS));
      end
   end

   assign board_full = &col_full;

`ifdef DROP_UNDO_EN
   logic             drop_ok;
   logic             undo_go;
   logic             hist_empty;
   logic             hist_full;
   logic [COL_W-1:0] undo_col;
   logic [HGT_W-1:0] undo_h;
   logic [POS_W-1:0] undo_pos;

   // A drop in the same cycle always wins over an undo
   assign drop_ok  = accept & sel_ok & ~col_full[sel_col];
   assign undo_go  = undo_req & ~accept & ~clear & ~hist_empty;
   assign undo_h   = height[undo_col] - 1'b1;
   assign undo_pos = POS_W'(slot_index(int'(undo_h), int'(undo_col), NUM_COLS));

   move_history_lifo #(
      .DEPTH  (NUM_COLS * NUM_ROWS),
      .DATA_W (COL_W)
   ) u_move_history_lifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .push      (drop_ok & ~hist_full),
      .push_data (sel_col),
      .pop       (undo_go),
      .empty     (hist_empty),
      .full      (hist_full),
      .data      (undo_col)
   );
`endif

   // Column heights and registered response; clear beats request, request beats undo
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_COLS; c++) height[c] <= '0;
         resp_valid    <= 1'b0;
         resp_position <= '0;
         resp_row      <= '0;
         resp_err      <= ERR_NONE;
`ifdef DROP_UNDO_EN
         undo_ack      <= 1'b0;
`endif
      end else begin
         resp_valid <= 1'b0;
`ifdef DROP_UNDO_EN
         undo_ack   <= 1'b0;
`endif
         if (clear) begin
            for (int c = 0; c < NUM_COLS; c++) height[c] <= '0;
         end else if (accept) begin
            resp_valid <= 1'b1;
            if (!sel_ok) begin
               resp_position <= '0;
               resp_row      <= '0;
               resp_err      <= ERR_BADSEL;
            end else if (col_full[sel_col]) begin
               resp_position <= '0;
               resp_row      <= '0;
               resp_err      <= ERR_FULL;
            end else begin
               resp_position   <= drop_pos;
               resp_row        <= ROW_W'(sel_h);
               resp_err        <= ERR_NONE;
               height[sel_col] <= sel_h + 1'b1;
            end
         end
`ifdef DROP_UNDO_EN
         else if (undo_go) begin
            undo_ack         <= 1'b1;
            resp_position    <= undo_pos;
            resp_row         <= ROW_W'(undo_h);
            resp_err         <= ERR_NONE;
            height[undo_col] <= undo_h;
         end
`endif
      end
   end

endmodule

// File: tb/tb_drop_slot_allocator.sv
// Scoreboard bench for drop_slot_allocator (4x4 board).
// Latency: expects each response one cycle after acceptance.
// Backpressure: drives clear to exercise req_ready low and dropped requests.
module tb_drop_slot_allocator;
   import connect4_pkg::*;

   typedef struct {
      logic [3:0] pos;
      logic [1:0] row;
      logic [1:0] err;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       clear;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_column;
   logic       resp_valid;
   logic [3:0] resp_position;
   logic [1:0] resp_row;
   logic [1:0] resp_err;
   logic [3:0] col_full;
   logic       board_full;
`ifdef DROP_UNDO_EN
   logic       undo_req;
   logic       undo_ack;
   logic [3:0] undo_q[$];
`endif

   exp_t exp_q[$];
   exp_t e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   run_len  = 0;
   int   max_run  = 0;

   drop_slot_allocator #(.NUM_COLS(4), .NUM_ROWS(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear         (clear),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_column    (req_column),
      .resp_valid    (resp_valid),
      .resp_position (resp_position),
      .resp_row      (resp_row),
      .resp_err      (resp_err),
      .col_full      (col_full),
`ifdef DROP_UNDO_EN
      .undo_req      (undo_req),
      .undo_ack      (undo_ack),
`endif
      .board_full    (board_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Monitor: pop the scoreboard whenever the DUT presents a response
   always @(negedge clk) begin
      if (resp_valid) begin
         run_len++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_resp: got resp_valid=1 pos=%0d, required no response", resp_position);
         end else begin
            e = exp_q.pop_front();
            check("resp_position", 32'(resp_position), 32'(e.pos));
            check("resp_row", 32'(resp_row), 32'(e.row));
            check("resp_err", 32'(resp_err), 32'(e.err));
         end
      end else begin
         run_len = 0;
      end
      if (run_len > max_run) max_run = run_len;
`ifdef DROP_UNDO_EN
      if (undo_ack) begin
         if (undo_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_undo_ack: got undo_ack=1 pos=%0d, required none", resp_position);
         end else begin
            check("undo_position", 32'(resp_position), 32'(undo_q.pop_front()));
         end
      end
`endif
   end

   task automatic drop(input logic [3:0] mask, input logic [3:0] pos,
                       input logic [1:0] row, input logic [1:0] err);
      @(posedge clk); #1;
      req_valid  = 1'b1;
      req_column = mask;
      exp_q.push_back('{pos: pos, row: row, err: err});
   endtask

   task automatic idle();
      @(posedge clk); #1;
      req_valid  = 1'b0;
      req_column = 4'hF;
   endtask

   task automatic clear_pulse();
      @(posedge clk); #1;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
   endtask

`ifdef DROP_UNDO_EN
   task automatic undo(input logic [3:0] pos);
      @(posedge clk); #1;
      undo_req = 1'b1;
      undo_q.push_back(pos);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      clear      = 1'b0;
      req_valid  = 1'b0;
      req_column = 4'hF;
`ifdef DROP_UNDO_EN
      undo_req   = 1'b0;
`endif
      #12;
      check("rst_resp_valid", 32'(resp_valid), 0);
      check("rst_resp_position", 32'(resp_position), 0);
      check("rst_resp_row", 32'(resp_row), 0);
      check("rst_resp_err", 32'(resp_err), 0);
      check("rst_col_full", 32'(col_full), 0);
      check("rst_board_full", 32'(board_full), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Four drops into column 1, then a fifth into the full column
      drop(4'b1101, 4'd1, 2'd0, ERR_NONE);
      drop(4'b1101, 4'd5, 2'd1, ERR_NONE);
      drop(4'b1101, 4'd9, 2'd2, ERR_NONE);
      drop(4'b1101, 4'd13, 2'd3, ERR_NONE);
      idle();
      check("col_full_after_4", 32'(col_full), 32'h2);
      check("board_full_after_4", 32'(board_full), 0);
      drop(4'b1101, 4'd0, 2'd0, ERR_FULL);
      idle();
      check("col_full_after_full", 32'(col_full), 32'h2);

      // Bad selects must not touch any column
      drop(4'b1100, 4'd0, 2'd0, ERR_BADSEL);
      drop(4'b1111, 4'd0, 2'd0, ERR_BADSEL);
      drop(4'b1110, 4'd0, 2'd0, ERR_NONE);
      drop(4'b1101, 4'd0, 2'd0, ERR_FULL);
      idle();

      // Fill the whole board back-to-back
      clear_pulse();
      check("col_full_after_clear", 32'(col_full), 0);
      max_run = 0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            logic [3:0] m;
            m = ~(4'b0001 << c);
            drop(m, 4'(r * 4 + c), 2'(r), ERR_NONE);
         end
      end
      idle();
      @(negedge clk); #1;
      check("burst_run_len", 32'(max_run), 16);
      check("board_full_set", 32'(board_full), 1);
      check("col_full_all", 32'(col_full), 32'hF);

      // Clear with a coincident request: request dropped, board empty
      @(posedge clk); #1;
      clear      = 1'b1;
      req_valid  = 1'b1;
      req_column = 4'b1110;
      #1;
      check("req_ready_during_clear", 32'(req_ready), 0);
      @(posedge clk); #1;
      clear      = 1'b0;
      req_valid  = 1'b0;
      req_column = 4'hF;
      check("col_full_after_clear_req", 32'(col_full), 0);
      check("board_full_after_clear_req", 32'(board_full), 0);
      drop(4'b1011, 4'd2, 2'd0, ERR_NONE);
      idle();

`ifdef DROP_UNDO_EN
      // Undo the last two drops in column 2, then drop there again
      clear_pulse();
      drop(4'b1110, 4'd0, 2'd0, ERR_NONE);
      drop(4'b1011, 4'd2, 2'd0, ERR_NONE);
      drop(4'b1011, 4'd6, 2'd1, ERR_NONE);
      idle();
      undo(4'd6);
      undo(4'd2);
      @(posedge clk); #1;
      undo_req = 1'b0;
      drop(4'b1011, 4'd2, 2'd0, ERR_NONE);
      idle();
      repeat (2) @(posedge clk);
      check("undo_q_drained", 32'(undo_q.size()), 0);
`endif

      // Asynchronous reset in the middle of a burst
      clear_pulse();
      drop(4'b1110, 4'd0, 2'd0, ERR_NONE);
      drop(4'b1110, 4'd4, 2'd1, ERR_NONE);
      drop(4'b1110, 4'd8, 2'd2, ERR_NONE);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_resp_valid", 32'(resp_valid), 0);
      check("async_rst_resp_position", 32'(resp_position), 0);
      check("async_rst_resp_row", 32'(resp_row), 0);
      check("async_rst_col_full", 32'(col_full), 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_column = 4'hF;
      @(negedge clk);
      rst_n = 1'b1;
      drop(4'b0111, 4'd3, 2'd0, ERR_NONE);
      drop(4'b1110, 4'd0, 2'd0, ERR_NONE);
      idle();
      repeat (3) @(posedge clk);
      check("exp_q_drained", 32'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
